piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter, MSB first, with registered serial_out/serial_valid/done.
// Define PISO_PARITY_EN to append an even-parity bit as an extra PARITY cycle after the data bits.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             done,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
`ifdef PISO_PARITY_EN
        ,
        ST_PARITY = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Handshake: a word is taken on a rising edge where load_valid && load_ready; load_valid is ignored otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
`ifdef PISO_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // serial_out is the shift register MSB, so the register drains to zero as the frame ends.
    always_comb begin
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    shreg_d  = parallel_in;
                    cnt_d    = CW'(WIDTH - 1);
                    valid_d  = 1'b1;
`ifdef PISO_PARITY_EN
                    parity_d = ^parallel_in;
`endif
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q - CW'(1);
                    valid_d = 1'b1;
`ifndef PISO_PARITY_EN
                    done_d  = (cnt_q == CW'(1));
`endif
                end else begin
`ifdef PISO_PARITY_EN
                    shreg_d = {parity_q, {(WIDTH-1){1'b0}}};
                    valid_d = 1'b1;
                    done_d  = 1'b1;
`else
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end
`endif
            default: begin
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q  <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign load_ready   = (state_q == ST_IDLE);
    assign serial_out   = shreg_q[WIDTH-1];
    assign serial_valid = valid_q;
    assign done         = done_q;
    assign dbg_state_o  = state_q;

endmodule
